mato_reader: RTL

MATO_READER -- requirements
Module: mato_reader

---
 rtl/mato_reader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mato_reader.sv
// Streams a DIM x DIM result matrix out of the O memory onto a valid/ready channel after ap_done.
// Optional build macro MATO_READER_TRANSPOSE_EN selects column-major (transposed) read order.
module mato_reader #(
  parameter int DIM    = 4,
  parameter int DATA_W = 16,
  parameter int ROW_AW = 32,
  parameter int COL_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_done,
  output logic              enO,
  output logic [ROW_AW-1:0] addrO_row,
  output logic [COL_AW-1:0] addrO_col,
  input  logic [DATA_W-1:0] dataO_out,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              rd_done
);

  localparam int N     = DIM * DIM;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DIM - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_row;
  logic [IDX_W-1:0]   r_col;
  logic [IDX_W-1:0]   w_row_nxt;
  logic [IDX_W-1:0]   w_col_nxt;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_elem;
  logic               r_ret;
  logic               r_hd_v;
  logic               r_tl_v;
  logic [DATA_W-1:0]  r_hd;
  logic [DATA_W-1:0]  r_tl;
  logic               w_hd_v_nxt;
  logic               w_tl_v_nxt;
  logic [DATA_W-1:0]  w_hd_nxt;
  logic [DATA_W-1:0]  w_tl_nxt;
  logic [1:0]         w_occ;
  logic               w_issue;
  logic               w_valid;
  logic               w_pop;
  logic               w_last;

  // Credit: buffered entries plus the read whose data is arriving now must leave room for one more.
  assign w_occ   = {1'b0, r_hd_v} + {1'b0, r_tl_v} + {1'b0, r_ret};
  assign w_issue = (r_state == S_READ) && (w_occ < 2'd2);
  assign w_valid = r_hd_v | r_ret;
  assign w_pop   = w_valid & m_ready;
  assign w_last  = (r_elem == CNT_LAST);

  assign enO       = w_issue;
  assign addrO_row = ROW_AW'(r_row);
  assign addrO_col = COL_AW'(r_col);
  assign m_valid   = w_valid;
  assign m_last    = w_valid & w_last;
  assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
  assign rd_done   = (r_state == S_DONE);

  // An empty buffer lets the returning word pass straight through as the head.
  always_comb begin
    m_data = '0;
    if (r_hd_v) begin
      m_data = r_hd;
    end else if (r_ret) begin
      m_data = dataO_out;
    end else begin
      m_data = '0;
    end
  end

  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (w_issue) begin
`ifdef MATO_READER_TRANSPOSE_EN
      if (r_row == IDX_MAX) begin
        w_row_nxt = '0;
        w_col_nxt = (r_col == IDX_MAX) ? '0 : r_col + IDX_W'(1);
      end else begin
        w_row_nxt = r_row + IDX_W'(1);
      end
`else
      if (r_col == IDX_MAX) begin
        w_col_nxt = '0;
        w_row_nxt = (r_row == IDX_MAX) ? '0 : r_row + IDX_W'(1);
      end else begin
        w_col_nxt = r_col + IDX_W'(1);
      end
`endif
    end else begin
      w_row_nxt = r_row;
      w_col_nxt = r_col;
    end
  end

  always_comb begin
    w_hd_v_nxt = r_hd_v;
    w_hd_nxt   = r_hd;
    w_tl_v_nxt = r_tl_v;
    w_tl_nxt   = r_tl;
    if (r_hd_v) begin
      if (w_pop && r_tl_v) begin
        w_hd_nxt   = r_tl;
        w_tl_v_nxt = r_ret;
        w_tl_nxt   = dataO_out;
      end else if (w_pop) begin
        w_hd_v_nxt = r_ret;
        w_hd_nxt   = dataO_out;
      end else if (r_ret) begin
        w_tl_v_nxt = 1'b1;
        w_tl_nxt   = dataO_out;
      end else begin
        w_hd_v_nxt = 1'b1;
      end
    end else if (r_ret && !w_pop) begin
      w_hd_v_nxt = 1'b1;
      w_hd_nxt   = dataO_out;
    end else begin
      w_hd_v_nxt = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = ap_done ? S_READ : S_IDLE;
      S_READ:  w_state_nxt = (w_issue && (r_issued == CNT_LAST)) ? S_DRAIN : S_READ;
      S_DRAIN: w_state_nxt = (w_pop && w_last) ? S_DONE : S_DRAIN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Clearing r_ret on reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_issued <= '0;
      r_elem   <= '0;
      r_ret    <= 1'b0;
      r_hd_v   <= 1'b0;
      r_tl_v   <= 1'b0;
      r_hd     <= '0;
      r_tl     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_ret   <= w_issue;
      r_hd_v  <= w_hd_v_nxt;
      r_tl_v  <= w_tl_v_nxt;
      r_hd    <= w_hd_nxt;
      r_tl    <= w_tl_nxt;
      if (r_state == S_DONE) begin
        r_issued <= '0;
        r_elem   <= '0;
      end else begin
        r_issued <= w_issue ? r_issued + CNT_W'(1) : r_issued;
        r_elem   <= w_pop ? r_elem + CNT_W'(1) : r_elem;
      end
    end
  end

endmodule
